// File: rtl/ds_operand_stage.sv
// Decode-to-execute operand stage: holds one decoded instruction, resolves rs/rt
// by youngest-first forwarding priority, and stalls while a matched result is not ready.
module ds_operand_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NFWD = 3,
    parameter int PW   = 64,
    parameter int CW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic [PW-1:0]        in_payload,
    input  logic [AW-1:0]        in_rs,
    input  logic [AW-1:0]        in_rt,
    input  logic                 in_use_rs,
    input  logic                 in_use_rt,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [DW-1:0]        rf_rdata1,
    input  logic [DW-1:0]        rf_rdata2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_addr,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*DW-1:0]   fwd_data,
    output logic                 out_valid,
    input  logic                 out_allowin,
    output logic [PW-1:0]        out_payload,
    output logic [DW-1:0]        out_src1,
    output logic [DW-1:0]        out_src2,
    output logic [CW-1:0]        stall_cnt
);

    logic            ds_valid_q, ds_valid_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic [AW-1:0]   rs_q, rs_d;
    logic [AW-1:0]   rt_q, rt_d;
    logic            use_rs_q, use_rs_d;
    logic            use_rt_q, use_rt_d;
    logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [DW:0]     res1, res2;
    logic            hazard;
    logic            ready_go;

    // Returns {hazard, value}; the first matching (youngest) source wins even if
    // it is not ready, so an older ready result can never bypass it.
    function automatic logic [DW:0] resolve(
        input logic [AW-1:0]      addr,
        input logic [DW-1:0]      rdata,
        input logic [NFWD-1:0]    v,
        input logic [NFWD-1:0]    we,
        input logic [NFWD-1:0]    rdy,
        input logic [NFWD*AW-1:0] fa,
        input logic [NFWD*DW-1:0] fd
    );
        logic        hit;
        logic [DW:0] r;
        hit = 1'b0;
        r   = {1'b0, rdata};
        if (addr == '0) begin
            r = '0;
        end else begin
            for (int i = 0; i < NFWD; i++) begin
                if (!hit && v[i] && we[i] && (fa[i*AW +: AW] == addr)) begin
                    hit = 1'b1;
                    r   = {!rdy[i], fd[i*DW +: DW]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        res1 = resolve(rs_q, rf_rdata1, fwd_valid, fwd_we, fwd_ready, fwd_addr, fwd_data);
        res2 = resolve(rt_q, rf_rdata2, fwd_valid, fwd_we, fwd_ready, fwd_addr, fwd_data);
    end

    assign hazard      = ds_valid_q && ((use_rs_q && res1[DW]) || (use_rt_q && res2[DW]));
    assign ready_go    = !hazard;
    assign out_valid   = ds_valid_q && ready_go && !flush;
    assign in_allowin  = !ds_valid_q || (ready_go && out_allowin);

    assign rf_raddr1   = rs_q;
    assign rf_raddr2   = rt_q;
    assign out_payload = payload_q;
    assign out_src1    = res1[DW-1:0];
    assign out_src2    = res2[DW-1:0];
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        ds_valid_d = ds_valid_q;
        payload_d  = payload_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        use_rs_d   = use_rs_q;
        use_rt_d   = use_rt_q;
        if (flush) begin
            ds_valid_d = 1'b0;
        end else if (in_allowin) begin
            ds_valid_d = in_valid;
            if (in_valid) begin
                payload_d = in_payload;
                rs_d      = in_rs;
                rt_d      = in_rt;
                use_rs_d  = in_use_rs;
                use_rt_d  = in_use_rt;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Instruction fields carry no reset; they are qualified by ds_valid_q.
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
        rs_q      <= rs_d;
        rt_q      <= rt_d;
        use_rs_q  <= use_rs_d;
        use_rt_q  <= use_rt_d;
    end

endmodule

// File: tb/tb_ds_operand_stage.sv
// Directed bench for ds_operand_stage with a scoreboard of expected EXE-side transfers.
module tb_ds_operand_stage;

    localparam int DW = 32, AW = 5, NFWD = 3, PW = 64, CW = 4;

    logic               clk = 1'b0;
    logic               reset, flush, in_valid, in_allowin;
    logic [PW-1:0]      in_payload;
    logic [AW-1:0]      in_rs, in_rt;
    logic               in_use_rs, in_use_rt;
    logic [AW-1:0]      rf_raddr1, rf_raddr2;
    logic [DW-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]    fwd_valid, fwd_we, fwd_ready;
    logic [NFWD*AW-1:0] fwd_addr;
    logic [NFWD*DW-1:0] fwd_data;
    logic               out_valid, out_allowin;
    logic [PW-1:0]      out_payload;
    logic [DW-1:0]      out_src1, out_src2;
    logic [CW-1:0]      stall_cnt;

    logic [DW-1:0]      rf_mem [32];

    typedef struct {
        logic [63:0] pl;
        logic [31:0] s1;
        logic [31:0] s2;
        bit          c2;
    } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        rf_rdata1 = rf_mem[rf_raddr1];
        rf_rdata2 = rf_mem[rf_raddr2];
    end

    ds_operand_stage #(.DW(DW), .AW(AW), .NFWD(NFWD), .PW(PW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_addr(fwd_addr),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
        .out_src1(out_src1), .out_src2(out_src2), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard check on the current cycle's transfer, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (out_valid && out_allowin) begin
            total++;
            assert (sbq.size() > 0) else begin
                bad++;
                $error("FAIL sb_unexpected observed=%0h expected=no_transfer", out_payload);
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_payload", out_payload, e.pl);
                chk("sb_src1", {32'h0, out_src1}, {32'h0, e.s1});
                if (e.c2) chk("sb_src2", {32'h0, out_src2}, {32'h0, e.s2});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic rdy, input logic [DW-1:0] d);
        fwd_valid[i]           = v;
        fwd_we[i]              = we;
        fwd_addr[i*AW +: AW]   = a;
        fwd_ready[i]           = rdy;
        fwd_data[i*DW +: DW]   = d;
    endtask

    task automatic clr_fwd();
        fwd_valid = '0; fwd_we = '0; fwd_addr = '0; fwd_ready = '0; fwd_data = '0;
    endtask

    task automatic drive_in(input logic [63:0] pl, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                            input logic urs, input logic urt);
        in_valid = 1'b1; in_payload = pl; in_rs = rs; in_rt = rt; in_use_rs = urs; in_use_rt = urt;
    endtask

    task automatic push(input logic [63:0] pl, input logic [31:0] s1, input logic [31:0] s2, input bit c2);
        exp_t e;
        e.pl = pl; e.s1 = s1; e.s2 = s2; e.c2 = c2;
        sbq.push_back(e);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf_mem[r] = 32'h100 + r;
        rf_mem[0] = '0; rf_mem[3] = 32'h11; rf_mem[4] = 32'h22;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_payload = '0;
        in_rs = '0; in_rt = '0; in_use_rs = 1'b0; in_use_rt = 1'b0; out_allowin = 1'b1;
        clr_fwd();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_allowin", in_allowin, 1);
        chk("rst_stall_cnt", stall_cnt, 0);

        // No hazard: RF operands, output in the cycle after capture
        drive_in(64'hA1, 5'd3, 5'd4, 1, 1); push(64'hA1, 32'h11, 32'h22, 1);
        #1; cycle();
        in_valid = 1'b0; #1;
        chk("nohaz_out_valid", out_valid, 1);
        chk("nohaz_stall_cnt", stall_cnt, 0);
        cycle();

        // Priority: fwd[0] beats fwd[2], then fwd[2] once fwd[0] is gone
        set_fwd(0, 1, 1, 5'd5, 1, 32'hA);
        set_fwd(2, 1, 1, 5'd5, 1, 32'hC);
        drive_in(64'hA2, 5'd5, 5'd4, 1, 1); push(64'hA2, 32'hA, 32'h22, 1);
        #1; cycle();
        in_valid = 1'b0; #1;
        chk("prio0_out_valid", out_valid, 1);
        cycle();
        set_fwd(0, 0, 1, 5'd5, 1, 32'hA);
        drive_in(64'hA3, 5'd5, 5'd4, 1, 1); push(64'hA3, 32'hC, 32'h22, 1);
        #1; cycle();
        in_valid = 1'b0; #1; cycle();
        clr_fwd();

        // Load-use stall for two cycles, release with a same-edge new capture
        set_fwd(0, 1, 1, 5'd7, 0, 32'h0);
        drive_in(64'hA4, 5'd7, 5'd4, 1, 1); push(64'hA4, 32'hDEAD, 32'h22, 1);
        #1; cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_out_valid", out_valid, 0);
            chk("stall_in_allowin", in_allowin, 0);
            cycle();
        end
        set_fwd(0, 1, 1, 5'd7, 1, 32'hDEAD);
        drive_in(64'hA5, 5'd3, 5'd0, 1, 1); push(64'hA5, 32'h11, 32'h0, 1);
        #1;
        chk("release_out_valid", out_valid, 1);
        chk("release_in_allowin", in_allowin, 1);
        chk("release_stall_cnt", stall_cnt, 2);
        cycle();
        clr_fwd(); in_valid = 1'b0; #1;
        chk("thru_out_valid", out_valid, 1);
        cycle();

        // r0 and unused operands never stall
        set_fwd(0, 1, 1, 5'd0, 0, 32'h55);
        set_fwd(1, 1, 1, 5'd9, 0, 32'h66);
        drive_in(64'hA6, 5'd0, 5'd9, 1, 0); push(64'hA6, 32'h0, 32'h0, 0);
        #1; cycle();
        in_valid = 1'b0; #1;
        chk("zero_out_valid", out_valid, 1);
        chk("zero_stall_cnt", stall_cnt, 2);
        cycle();
        clr_fwd();

        // Flush during a stall; the offered beat is dropped and not counted
        set_fwd(0, 1, 1, 5'd7, 0, 32'h0);
        drive_in(64'hA7, 5'd7, 5'd4, 1, 1);
        #1; cycle();
        in_valid = 1'b0; #1;
        chk("fl_pre_out_valid", out_valid, 0);
        cycle();
        flush = 1'b1; drive_in(64'hA8, 5'd3, 5'd4, 1, 1); #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_stall_cnt", stall_cnt, 3);
        cycle();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("fl_post_out_valid", out_valid, 0);
        chk("fl_post_in_allowin", in_allowin, 1);
        chk("fl_post_stall_cnt", stall_cnt, 3);
        cycle();
        clr_fwd();

        // Flush of a ready instruction while a new beat is offered with in_allowin=1
        drive_in(64'hA9, 5'd3, 5'd4, 1, 1);
        #1; cycle();
        flush = 1'b1; drive_in(64'hAA, 5'd3, 5'd4, 1, 1); #1;
        chk("fl2_out_valid", out_valid, 0);
        chk("fl2_in_allowin", in_allowin, 1);
        cycle();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("fl2_post_out_valid", out_valid, 0);
        cycle();

        // Back-pressure holds state; operands re-resolve when the RF changes
        out_allowin = 1'b0;
        drive_in(64'hAB, 5'd3, 5'd4, 1, 1); push(64'hAB, 32'h33, 32'h22, 1);
        #1; cycle();
        drive_in(64'hAC, 5'd4, 5'd3, 1, 1); #1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_allowin", in_allowin, 0);
        chk("bp_payload0", out_payload, 64'hAB);
        cycle();
        chk("bp_payload1", out_payload, 64'hAB);
        chk("bp_src1_old", {32'h0, out_src1}, 64'h11);
        rf_mem[3] = 32'h33; out_allowin = 1'b1; push(64'hAC, 32'h22, 32'h33, 1);
        #1;
        chk("bp_release_allowin", in_allowin, 1);
        cycle();
        in_valid = 1'b0; #1;
        chk("bp_next_out_valid", out_valid, 1);
        cycle();

        // Saturation at 2^CW-1, then reset mid-stall
        reset = 1'b1; cycle(); reset = 1'b0; #1;
        chk("rst2_stall_cnt", stall_cnt, 0);
        set_fwd(0, 1, 1, 5'd7, 0, 32'h0);
        drive_in(64'hAD, 5'd7, 5'd4, 1, 1);
        #1; cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) chk("sat_mid", stall_cnt, 10);
            cycle();
        end
        chk("sat_cnt", stall_cnt, 15);
        chk("sat_out_valid", out_valid, 0);
        reset = 1'b1; cycle(); reset = 1'b0; #1;
        chk("rst3_stall_cnt", stall_cnt, 0);
        chk("rst3_out_valid", out_valid, 0);
        chk("rst3_in_allowin", in_allowin, 1);
        clr_fwd();
        cycle();

        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
